ddr_to_rgb: RTL and testbench
=============================

// Module: ddr_to_rgb
// PURPOSE
//  Read-back stage downstream of the DDR write path. It fetches a frame buffer from LPDDR through MCB port 1
//  in 64-word read bursts and unpacks each 32-bit word into a 24-bit pixel. Pixels are pushed into the
//  display pixel FIFO that feeds the video output. The frame is scanned cyclically from BASE_ADDR and wraps
//  after FRAME_BYTES.
// PARAMETERS
//  RGB_WIDTH         24         pixel width; the pixel is rd_data[RGB_WIDTH-1:0]
//  DATA_COUNT_WIDTH  11         width of the pixel FIFO write count
//  FIFO_DEPTH        2048       pixel FIFO depth, in words
//  BURST_WORDS       64         words per read command; cmd_bl = BURST_WORDS-1
//  BASE_ADDR         30'h0      byte address of the frame start
//  FRAME_BYTES       1228800    frame size in bytes (640x480x4); must be a multiple of BURST_WORDS*4
// PORTS
//  clk                  in   1    system clock; MCB port 1 and the pixel FIFO write side run on it
//  rst                  in   1    reset: asynchronous assert, active-low
//  c3_calib_done        in   1    MCB calibration complete
//  c3_p1_cmd_en         out  1    command push strobe (one-cycle pulse)
//  c3_p1_cmd_instr      out  3    3'b011 = read with auto-precharge
//  c3_p1_cmd_bl         out  6    burst length minus 1
//  c3_p1_cmd_byte_addr  out  30   burst start byte address
//  c3_p1_cmd_empty      in   1    command FIFO empty (unused; observed only by the bench)
//  c3_p1_cmd_full       in   1    command FIFO full
//  c3_p1_rd_en          out  1    read-data FIFO pop
//  c3_p1_rd_data        in   32   read data; valid while !rd_empty (first-word fall-through)
//  c3_p1_rd_empty       in   1    read-data FIFO empty
//  c3_p1_rd_full        in   1    read-data FIFO full (unused)
//  c3_p1_rd_count       in   7    read-data FIFO level (unused)
//  c3_p1_rd_overflow    in   1    MCB overflow flag
//  c3_p1_rd_error       in   1    MCB error flag
//  fifo_data_in         out  24   pixel to the display FIFO
//  fifo_write_enable    out  1    pixel FIFO push
//  fifo_wr_data_count   in   11   pixel FIFO occupancy
//  fifo_full            in   1    pixel FIFO full
//  frame_done           out  1    one-cycle pulse when the address wraps
//  error                out  1    sticky, set by rd_overflow or rd_error
//  led                  out  8    {error, calib_done, state[2:0], frame_cnt[2:0]}
// BEHAVIOUR
//  Reset values: all outputs 0; addr_ptr = BASE_ADDR; word_cnt = 0; state = WAIT_CALIB.
//  States and transitions:
//  - WAIT_CALIB: move to WAIT_SPACE when c3_calib_done = 1.
//  - WAIT_SPACE: move to READ_CMD when fifo_wr_data_count <= FIFO_DEPTH-BURST_WORDS. The comparison is unsigned.
//  - READ_CMD: when !cmd_full, pulse cmd_en for one cycle with instr = 3'b011, bl = BURST_WORDS-1,
//    byte_addr = addr_ptr, then go to READ_DATA. While cmd_full, hold and do not pulse.
//  - READ_DATA:
//    - rd_en = !rd_empty && !fifo_full && (word_cnt != BURST_WORDS). This term is combinational from
//      registered state and the inputs.
//    - On each pop, register fifo_data_in <= rd_data[23:0] and fifo_write_enable <= 1 (a one-cycle
//      pipeline); otherwise fifo_write_enable <= 0.
//    - word_cnt increments on each pop. When word_cnt reaches BURST_WORDS, clear it and go to ADVANCE.
//  - ADVANCE: addr_ptr += BURST_WORDS*4. If the new address would be >= BASE_ADDR+FRAME_BYTES, load
//    BASE_ADDR instead, pulse frame_done and increment frame_cnt (3-bit, wraps). Return to WAIT_SPACE.
//  Latency: first pixel write lands 1 cycle after the first pop.
//  Throughput: 1 pixel per cycle while data is present.
//  Exactly one command is outstanding at any time. A new command is never issued until all BURST_WORDS
//  words have been popped.
//  Boundary conditions:
//  - fifo_full during a burst: stall pops, no data lost, resume on deassert.
//  - rd_empty gaps: stall pops; no timeout.
//  - cmd_full and calib loss: calib_done dropping mid-frame is ignored.
//  - Simultaneous overflow and error: error is set, no other effect.
//  - Reset mid-burst: immediate return to reset values. The MCB port is expected to be reset alongside.
//  Arithmetic: addr_ptr is 30-bit unsigned; word_cnt is 7-bit.
// STRUCTURE
//  Shared package: MCB instruction codes (WRITE, READ, WRITE_AUTO_PRECHARGE, READ_AUTO_PRECHARGE),
//  BURST_WORDS, and frame geometry constants shared with the write side.
//  Single module; no sub-module. The unpacking is a slice, not worth a separate block.
// TESTING
//  1. calib_done low 100 cycles -> no cmd_en. Raise it with empty FIFO -> cmd_en at addr 0, bl = 63,
//     instr = 3'b011.
//  2. MCB model returns 64 words 0xAA000000+i -> 64 pixel writes 0x000000..0x00003F in order, then a second
//     command at addr 0x100.
//  3. fifo_wr_data_count = 1985 -> no command. Drop it to 1984 -> command issued next state cycle.
//  4. Hold fifo_full for 10 cycles mid-burst -> rd_en = 0 throughout, no pixel dropped or duplicated,
//     64 total.
//  5. Run FRAME_BYTES = 512 -> addresses 0, 0x100, 0; frame_done pulses once per wrap; frame_cnt increments.
//  6. Assert rst low mid-burst, then pulse rd_error -> outputs zero and addr = BASE_ADDR after reset;
//     error is sticky after rd_error.

Source files
------------

// File: rtl/ddr_to_rgb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_to_rgb_pkg
//  Brief    : MCB command codes, burst size, frame geometry and read-side FSM states.
//  Revision : 1.0
// ============================================================================
package ddr_to_rgb_pkg;

    typedef enum logic [2:0] {
        MCB_WRITE                = 3'b000,
        MCB_READ                 = 3'b001,
        MCB_WRITE_AUTO_PRECHARGE = 3'b010,
        MCB_READ_AUTO_PRECHARGE  = 3'b011
    } mcb_instr_e;

    localparam int MCB_BURST_WORDS     = 64;
    localparam int H_ACTIVE            = 640;
    localparam int V_ACTIVE            = 480;
    localparam int BYTES_PER_PIXEL     = 4;
    localparam int FRAME_BYTES_DEFAULT = H_ACTIVE * V_ACTIVE * BYTES_PER_PIXEL;

    typedef enum logic [2:0] {
        ST_WAIT_CALIB = 3'd0,
        ST_WAIT_SPACE = 3'd1,
        ST_READ_CMD   = 3'd2,
        ST_READ_DATA  = 3'd3,
        ST_ADVANCE    = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ddr_to_rgb.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_to_rgb
//  Brief    : Cyclic frame-buffer read-back over MCB port 1, unpacking words into pixels.
//  Revision : 1.0
// ============================================================================
module ddr_to_rgb
    import ddr_to_rgb_pkg::*;
#(
    parameter int          RGB_WIDTH        = 24,
    parameter int          DATA_COUNT_WIDTH = 11,
    parameter int          FIFO_DEPTH       = 2048,
    parameter int          BURST_WORDS      = MCB_BURST_WORDS,
    parameter logic [29:0] BASE_ADDR        = 30'h0,
    parameter int          FRAME_BYTES      = FRAME_BYTES_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        c3_calib_done,
    output logic                        c3_p1_cmd_en,
    output logic [2:0]                  c3_p1_cmd_instr,
    output logic [5:0]                  c3_p1_cmd_bl,
    output logic [29:0]                 c3_p1_cmd_byte_addr,
    input  logic                        c3_p1_cmd_empty,
    input  logic                        c3_p1_cmd_full,
    output logic                        c3_p1_rd_en,
    input  logic [31:0]                 c3_p1_rd_data,
    input  logic                        c3_p1_rd_empty,
    input  logic                        c3_p1_rd_full,
    input  logic [6:0]                  c3_p1_rd_count,
    input  logic                        c3_p1_rd_overflow,
    input  logic                        c3_p1_rd_error,
    output logic [RGB_WIDTH-1:0]        fifo_data_in,
    output logic                        fifo_write_enable,
    input  logic [DATA_COUNT_WIDTH-1:0] fifo_wr_data_count,
    input  logic                        fifo_full,
    output logic                        frame_done,
    output logic                        error,
    output logic [7:0]                  led
);

    localparam logic [30:0] C_BURST_BYTES = 31'(BURST_WORDS * 4);
    localparam logic [30:0] C_FRAME_END   = {1'b0, BASE_ADDR} + 31'(FRAME_BYTES);
    localparam logic [31:0] C_SPACE_LIMIT = 32'(FIFO_DEPTH - BURST_WORDS);
    localparam logic [6:0]  C_BURST_FULL  = 7'(BURST_WORDS);
    localparam logic [6:0]  C_BURST_LAST  = 7'(BURST_WORDS - 1);
    localparam logic [5:0]  C_CMD_BL      = 6'(BURST_WORDS - 1);

    state_e      r_state;
    logic [29:0] r_addr_ptr;
    logic [6:0]  r_word_cnt;
    logic [2:0]  r_frame_cnt;
    logic        r_error;

    logic        w_rd_en;
    logic [30:0] w_next_addr;
    logic        w_unused;

    // Pop only while a burst is in flight and the pixel FIFO can take the word.
    assign w_rd_en = (r_state == ST_READ_DATA) && !c3_p1_rd_empty && !fifo_full
                     && (r_word_cnt != C_BURST_FULL);
    assign w_next_addr = {1'b0, r_addr_ptr} + C_BURST_BYTES;

    assign c3_p1_rd_en = w_rd_en;
    assign error       = r_error;
    assign led         = {r_error, c3_calib_done, 3'(r_state), r_frame_cnt};

    assign w_unused = ^{c3_p1_cmd_empty, c3_p1_rd_full, c3_p1_rd_count,
                        c3_p1_rd_data[31:RGB_WIDTH]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state             <= ST_WAIT_CALIB;
            r_addr_ptr          <= BASE_ADDR;
            r_word_cnt          <= '0;
            r_frame_cnt         <= '0;
            r_error             <= 1'b0;
            c3_p1_cmd_en        <= 1'b0;
            c3_p1_cmd_instr     <= '0;
            c3_p1_cmd_bl        <= '0;
            c3_p1_cmd_byte_addr <= '0;
            fifo_data_in        <= '0;
            fifo_write_enable   <= 1'b0;
            frame_done          <= 1'b0;
        end else begin
            c3_p1_cmd_en      <= 1'b0;
            fifo_write_enable <= 1'b0;
            frame_done        <= 1'b0;
            if (c3_p1_rd_overflow || c3_p1_rd_error) begin
                r_error <= 1'b1;
            end
            case (r_state)
                ST_WAIT_CALIB: begin
                    if (c3_calib_done) begin
                        r_state <= ST_WAIT_SPACE;
                    end
                end
                ST_WAIT_SPACE: begin
                    if (32'(fifo_wr_data_count) <= C_SPACE_LIMIT) begin
                        r_state <= ST_READ_CMD;
                    end
                end
                ST_READ_CMD: begin
                    if (!c3_p1_cmd_full) begin
                        c3_p1_cmd_en        <= 1'b1;
                        c3_p1_cmd_instr     <= MCB_READ_AUTO_PRECHARGE;
                        c3_p1_cmd_bl        <= C_CMD_BL;
                        c3_p1_cmd_byte_addr <= r_addr_ptr;
                        r_state             <= ST_READ_DATA;
                    end
                end
                ST_READ_DATA: begin
                    if (w_rd_en) begin
                        fifo_data_in      <= c3_p1_rd_data[RGB_WIDTH-1:0];
                        fifo_write_enable <= 1'b1;
                        if (r_word_cnt == C_BURST_LAST) begin
                            r_word_cnt <= '0;
                            r_state    <= ST_ADVANCE;
                        end else begin
                            r_word_cnt <= r_word_cnt + 7'd1;
                        end
                    end
                end
                ST_ADVANCE: begin
                    if (w_next_addr >= C_FRAME_END) begin
                        r_addr_ptr  <= BASE_ADDR;
                        frame_done  <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 3'd1;
                    end else begin
                        r_addr_ptr <= w_next_addr[29:0];
                    end
                    r_state <= ST_WAIT_SPACE;
                end
                default: r_state <= ST_WAIT_CALIB;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr_to_rgb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_to_rgb
//  Brief    : Scoreboard bench with an MCB port-1 read model; small frame to exercise wrap.
//  Revision : 1.0
// ============================================================================
module tb_ddr_to_rgb;

    localparam int FRAME_BYTES = 512;
    localparam int BURST_WORDS = 64;
    localparam int BURST_BYTES = BURST_WORDS * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        calib_done;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_empty;
    logic        cmd_full;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_empty;
    logic        rd_full;
    logic [6:0]  rd_count;
    logic        rd_overflow;
    logic        rd_error;
    logic [23:0] fifo_data_in;
    logic        fifo_write_enable;
    logic [10:0] fifo_wr_data_count;
    logic        fifo_full;
    logic        frame_done;
    logic        error;
    logic [7:0]  led;

    always #5 clk = ~clk;

    ddr_to_rgb #(.FRAME_BYTES(FRAME_BYTES)) dut (
        .clk(clk), .rst(rst), .c3_calib_done(calib_done),
        .c3_p1_cmd_en(cmd_en), .c3_p1_cmd_instr(cmd_instr), .c3_p1_cmd_bl(cmd_bl),
        .c3_p1_cmd_byte_addr(cmd_byte_addr), .c3_p1_cmd_empty(cmd_empty),
        .c3_p1_cmd_full(cmd_full), .c3_p1_rd_en(rd_en), .c3_p1_rd_data(rd_data),
        .c3_p1_rd_empty(rd_empty), .c3_p1_rd_full(rd_full), .c3_p1_rd_count(rd_count),
        .c3_p1_rd_overflow(rd_overflow), .c3_p1_rd_error(rd_error),
        .fifo_data_in(fifo_data_in), .fifo_write_enable(fifo_write_enable),
        .fifo_wr_data_count(fifo_wr_data_count), .fifo_full(fifo_full),
        .frame_done(frame_done), .error(error), .led(led)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] mcb_q[$];
    logic [23:0] exp_pix[$];
    int  words_left     = 0;
    int  cmd_cnt        = 0;
    int  pix_cnt        = 0;
    int  frame_done_cnt = 0;
    int  delay          = 0;
    bit  gaps_en        = 1'b0;
    bit  cmd_full_en    = 1'b0;
    bit  pattern_en     = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Burst k of a scan starts k bursts into the frame, modulo the frame size.
    function automatic logic [63:0] expected_addr(input int k);
        return 64'((longint'(k) * BURST_BYTES) % FRAME_BYTES);
    endfunction

    function automatic logic [63:0] expected_wraps(input int k);
        return 64'((longint'(k) * BURST_BYTES) / FRAME_BYTES);
    endfunction

    // MCB port-1 model: accepts read commands and serves words first-word-fall-through.
    initial begin
        bit present;
        logic [31:0] w;
        rd_empty = 1'b1; rd_data = '0; cmd_full = 1'b0; cmd_empty = 1'b1;
        rd_full = 1'b0; rd_count = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mcb_q.delete();
                words_left = 0; cmd_cnt = 0; delay = 0;
                rd_empty = 1'b1; cmd_full = 1'b0;
            end else begin
                if (cmd_en) begin
                    check("cmd_one_outstanding", 64'(words_left), 64'd0);
                    check("cmd_not_while_full", 64'(cmd_full), 64'd0);
                    check("cmd_addr", 64'(cmd_byte_addr), expected_addr(cmd_cnt));
                    check("cmd_bl", 64'(cmd_bl), 64'd63);
                    check("cmd_instr", 64'(cmd_instr), 64'd3);
                    check("frame_done_count", 64'(frame_done_cnt), expected_wraps(cmd_cnt));
                    check("frame_cnt_led", 64'(led[2:0]), expected_wraps(cmd_cnt) % 8);
                    for (int i = 0; i < BURST_WORDS; i++) begin
                        w = pattern_en ? 32'hAA00_0000 + 32'(i) : $urandom;
                        mcb_q.push_back(w);
                        exp_pix.push_back(w[23:0]);
                    end
                    pattern_en = 1'b0;
                    words_left = BURST_WORDS;
                    delay = $urandom_range(1, 6);
                    cmd_cnt++;
                end
                if (delay > 0) delay--;
                present  = (mcb_q.size() > 0) && (delay == 0) && !(gaps_en && $urandom_range(0, 3) == 0);
                rd_empty = !present;
                rd_data  = present ? mcb_q[0] : $urandom;
                cmd_full = cmd_full_en && ($urandom_range(0, 2) == 0);
                #1;
                if (fifo_full) check("rd_en_stall_on_full", 64'(rd_en), 64'd0);
                if (rd_en) begin
                    if (!present) begin
                        checks++; errors++;
                        $display("FAIL rd_en_while_empty: actual=1 required=0");
                    end else begin
                        void'(mcb_q.pop_front());
                        words_left--;
                    end
                end
            end
        end
    end

    // Monitor: every pixel write is compared against the scoreboard in order.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                exp_pix.delete();
                pix_cnt = 0; frame_done_cnt = 0;
            end else begin
                if (frame_done) frame_done_cnt++;
                if (fifo_write_enable) begin
                    pix_cnt++;
                    if (exp_pix.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL pixel_unexpected: actual=0x%0h required=none", fifo_data_in);
                    end else begin
                        e = exp_pix.pop_front();
                        check("pixel", 64'(fifo_data_in), 64'(e));
                    end
                end
            end
        end
    end

    task automatic wait_cmds(input int n, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #2;
            if (cmd_cnt >= n) ok = 1'b1;
        end
        check("wait_cmds_in_time", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #2;
            if (exp_pix.size() == 0 && words_left == 0 && mcb_q.size() == 0) ok = 1'b1;
        end
        check("wait_idle_in_time", 64'(ok), 64'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_en", 64'(cmd_en), 64'd0);
        check("rst_cmd_instr", 64'(cmd_instr), 64'd0);
        check("rst_cmd_bl", 64'(cmd_bl), 64'd0);
        check("rst_cmd_addr", 64'(cmd_byte_addr), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_fifo_data", 64'(fifo_data_in), 64'd0);
        check("rst_fifo_we", 64'(fifo_write_enable), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_led", 64'(led), 64'd0);
    endtask

    initial begin
        bit found;
        rst = 1'b0; calib_done = 1'b0; fifo_wr_data_count = '0; fifo_full = 1'b0;
        rd_error = 1'b0; rd_overflow = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs();
        @(negedge clk); #2 rst = 1'b1;

        // No command while calibration is pending, then the first command at the frame base.
        repeat (100) @(negedge clk);
        #2 check("no_cmd_before_calib", 64'(cmd_cnt), 64'd0);
        calib_done = 1'b1;
        wait_cmds(1, 20);

        // Space threshold: 1985 holds off the next command, 1984 releases it.
        fifo_wr_data_count = 11'd1985;
        wait_idle(600);
        check("first_burst_pixels", 64'(pix_cnt), 64'd64);
        repeat (30) @(negedge clk);
        #2 check("no_cmd_at_1985", 64'(cmd_cnt), 64'd1);
        fifo_wr_data_count = 11'd1984;
        wait_cmds(2, 3);
        fifo_wr_data_count = 11'd0;

        // Pixel FIFO full mid-burst, with a calibration drop that must be ignored.
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk); #2;
            if (pix_cnt >= 84) found = 1'b1;
        end
        check("reached_mid_burst", 64'(found), 64'd1);
        @(negedge clk);
        fifo_full = 1'b1; calib_done = 1'b0;
        repeat (10) @(negedge clk);
        fifo_full = 1'b0; calib_done = 1'b1;
        wait_idle(600);
        check("second_burst_pixels", 64'(pix_cnt), 64'd128);

        // Randomised traffic: read gaps, back-pressure, command FIFO full, space threshold.
        gaps_en = 1'b1; cmd_full_en = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            fifo_full = ($urandom_range(0, 4) == 0);
            fifo_wr_data_count = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(1985, 2047))
                                                             : 11'($urandom_range(0, 1984));
        end
        @(negedge clk);
        fifo_full = 1'b0; fifo_wr_data_count = '0; gaps_en = 1'b0; cmd_full_en = 1'b0;
        wait_idle(600);
        check("random_bursts_progress", 64'(cmd_cnt >= 8), 64'd1);

        // Overflow and error together only set the sticky flag.
        check("error_clear_before", 64'(error), 64'd0);
        @(negedge clk); rd_overflow = 1'b1; rd_error = 1'b1;
        @(negedge clk); rd_overflow = 1'b0; rd_error = 1'b0;
        #1 check("error_set", 64'(error), 64'd1);
        check("error_led", 64'(led[7]), 64'd1);

        // Reset mid-burst returns everything to reset values and restarts at the base.
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk); #2;
            if (exp_pix.size() >= 10 && exp_pix.size() <= 50) found = 1'b1;
        end
        check("reached_mid_burst_for_reset", 64'(found), 64'd1);
        rst = 1'b0; calib_done = 1'b0;
        @(negedge clk);
        #1 check_reset_outputs();
        @(negedge clk); #2 rst = 1'b1; calib_done = 1'b1;
        wait_cmds(1, 20);
        @(negedge clk); rd_error = 1'b1;
        @(negedge clk); rd_error = 1'b0;
        repeat (20) @(negedge clk);
        #1 check("error_sticky", 64'(error), 64'd1);
        wait_idle(600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
